// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: four-digit multiplexed display scanner with double-buffered updates.
// Define DISP_DIMMING_EN to enable 16-level brightness slicing of the ON phase.
module display_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LOAD,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP_IN,
  input  logic [3:0]  DIG_EN,
  input  logic [3:0]  BRIGHT,
  output logic [3:0]  DIG,
  output logic [3:0]  HEX,
  output logic        DP,
  output logic        FRAME,
  output logic        PEND
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] C_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
  typedef enum logic {S_BLANK, S_ON} state_t;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_c, w_c_nxt;
  logic [1:0]    r_slot;
  logic [23:0]   r_act, r_pnd, w_act_nxt, w_in;
  logic [15:0]   w_data;
  logic [3:0]    w_dp, w_en, w_dig_nxt;
  logic          r_pend, w_commit, w_dim_ok;
  assign w_in     = {DIG_EN, DP_IN, DATA};
  assign w_commit = (r_c == '0) && (r_slot == 2'd0);
  assign w_c_nxt  = (r_c == C_LAST) ? '0 : r_c + 1'b1;
  // a LOAD on the commit edge bypasses the pending buffer entirely
  assign w_act_nxt = !w_commit ? r_act : LOAD ? w_in : r_pend ? r_pnd : r_act;
  assign w_data   = w_act_nxt[15:0];
  assign w_dp     = w_act_nxt[19:16];
  assign w_en     = r_act[23:20];
  assign PEND     = r_pend;
`ifdef DISP_DIMMING_EN
  localparam int SLICE = (CLK_DIV - BLANK_CYCLES) / 16;
  logic [31:0] w_on_off;
  assign w_on_off = 32'(r_c) - 32'(BLANK_CYCLES);
  assign w_dim_ok = w_on_off < 32'(BRIGHT) * 32'(SLICE);
`else
  logic w_unused_bright;
  assign w_unused_bright = ^BRIGHT;
  assign w_dim_ok = 1'b1;
`endif
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_state <= S_BLANK;
    else        r_state <= w_state_nxt;
  always_comb
    w_state_nxt = (w_c_nxt == '0) ? S_BLANK : (w_c_nxt == C_BLANK) ? S_ON : r_state;
  always_comb
    w_dig_nxt = (r_state == S_ON && w_en[r_slot] && w_dim_ok) ? ~(4'b0001 << r_slot) : 4'hF;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_c    <= '0;
      r_slot <= '0;
      r_act  <= '0;
      r_pnd  <= '0;
      r_pend <= 1'b0;
      DIG    <= 4'hF;
      HEX    <= '0;
      DP     <= 1'b0;
      FRAME  <= 1'b0;
    end else begin
      r_c    <= w_c_nxt;
      if (r_c == C_LAST) r_slot <= r_slot + 1'b1;
      r_act  <= w_act_nxt;
      if (LOAD) r_pnd <= w_in;
      r_pend <= !w_commit && (LOAD || r_pend);
      DIG    <= w_dig_nxt;
      FRAME  <= w_commit;
      if (r_c == '0) begin
        HEX <= w_data[{r_slot, 2'b00} +: 4];
        DP  <= w_dp[r_slot];
      end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench; a frame-level reference model predicts every output cycle.
module tb_display_scan_ctrl;
  localparam int DIV = 64, BLANK = 16, SLICE = (DIV - BLANK) / 16, FRM = 4 * DIV;
  logic CLK = 0, RST_N = 0, LOAD = 0;
  logic [15:0] DATA = 0;
  logic [3:0] DP_IN = 0, DIG_EN = 0, BRIGHT = 0;
  logic [3:0] DIG, HEX;
  logic DP, FRAME, PEND;
  int n_chk = 0, n_fail = 0, mt = 0;
  typedef struct packed {logic [3:0] en; logic [3:0] dp; logic [15:0] d;} buf_t;
  buf_t m_act = '0, m_pnd = '0;
  bit m_pend = 0;
  logic [10:0] exp_q[$];

  display_scan_ctrl #(.CLK_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .DATA(DATA), .DP_IN(DP_IN), .DIG_EN(DIG_EN),
    .BRIGHT(BRIGHT), .DIG(DIG), .HEX(HEX), .DP(DP), .FRAME(FRAME), .PEND(PEND));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got dig=%b hex=%h dp=%b frame=%b pend=%b expected dig=%b hex=%h dp=%b frame=%b pend=%b",
               nm, $time, act[10:7], act[6:3], act[2], act[1], act[0], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Reference model: count k since reset is slot (k/DIV)%4, cycle k%DIV; frame starts every FRM counts.
  always @(posedge CLK or negedge RST_N) begin
    int c, s;
    bit lit;
    if (!RST_N) begin
      mt = 0; m_act = '0; m_pnd = '0; m_pend = 0;
      exp_q.delete();
    end else begin
      c = mt % DIV;
      s = (mt / DIV) % 4;
      if (mt % FRM == 0) begin
        if (LOAD) m_act = {DIG_EN, DP_IN, DATA};
        else if (m_pend) m_act = m_pnd;
        m_pend = 0;
      end else if (LOAD) begin
        m_pnd = {DIG_EN, DP_IN, DATA};
        m_pend = 1;
      end
      lit = (c >= BLANK) && m_act.en[s];
`ifdef DISP_DIMMING_EN
      lit = lit && ((c - BLANK) / SLICE < int'(BRIGHT));
`endif
      exp_q.push_back({lit ? ~(4'b0001 << s) : 4'hF, m_act.d[4*s +: 4], m_act.dp[s], mt % FRM == 0, m_pend});
      mt++;
    end
  end

  always @(negedge CLK)
    if (RST_N && exp_q.size() > 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      chk("scan", {DIG, HEX, DP, FRAME, PEND}, e);
      n_chk++;
      if ($countones(~DIG) > 1) begin
        n_fail++;
        $display("FAIL onehot t=%0t got dig=%b expected at most one low bit", $time, DIG);
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    LOAD = 1; DATA = d; DP_IN = dp; DIG_EN = en;
    @(negedge CLK);
    LOAD = 0; DATA = $urandom; DP_IN = $urandom; DIG_EN = $urandom;
  endtask

  task automatic wait_cnt(input int v);
    int i;
    for (i = 0; i < 2 * FRM && (mt % FRM) != v; i++) @(negedge CLK);
    if ((mt % FRM) != v) begin
      n_chk++; n_fail++;
      $display("FAIL wait_cnt got count=%0d expected %0d", mt % FRM, v);
    end
  endtask

  initial begin
    BRIGHT = 4'd15;
    cyc(3);
    RST_N = 1;
    cyc(2 * FRM + 10);
    BRIGHT = 4'd4;
    wait_cnt(100);
    load(16'h4321, 4'b0101, 4'hF);
    cyc(2 * FRM);
    wait_cnt(20);
    load(16'h1111, 4'h0, 4'hF);
    cyc(50);
    load(16'h2222, 4'h3, 4'hF);
    cyc(FRM);
    BRIGHT = 4'd0;
    wait_cnt(0);
    load(16'h9A5C, 4'hA, 4'hF);
    cyc(FRM);
    BRIGHT = 4'd15;
    wait_cnt(40);
    load(16'hBEEF, 4'hF, 4'b0101);
    cyc(2 * FRM);
    for (int i = 0; i < 6 * FRM; i++) begin
      LOAD = ($urandom_range(0, 79) == 0);
      DATA = $urandom; DP_IN = $urandom; DIG_EN = $urandom;
      if ($urandom_range(0, 199) == 0) BRIGHT = $urandom;
      @(negedge CLK);
    end
    LOAD = 0;
    wait_cnt(10);
    load(16'h7777, 4'hF, 4'hF);
    wait_cnt(2 * DIV + 31);
    chk("pend_before_rst", {7'd0, FRAME, PEND} & 11'h1, 11'h1);
    #2 RST_N = 0;
    #1 chk("rst_async", {DIG, HEX, DP, FRAME, PEND}, {4'hF, 4'h0, 1'b0, 1'b0, 1'b0});
    @(negedge CLK);
    RST_N = 1;
    cyc(2 * FRM + 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: CLK cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYCLES, default 2000: all-digits-off cycles at the start of each slot (anti-ghosting).
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on posedge CLK.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port LOAD  input  1  one-cycle strobe that captures DATA, DP_IN and DIG_EN into the pending buffer.
REQ-006 SHALL have port DATA  input  16  four hex digits; bits [4n+3:4n] belong to digit n.
REQ-007 SHALL have port DP_IN  input  4  decimal point per digit, active-high.
REQ-008 SHALL have port DIG_EN  input  4  per-digit enable; 0 keeps that digit dark.
REQ-009 SHALL have port BRIGHT  input  4  brightness level 0..15, sampled live.
REQ-010 SHALL have port DIG  output  4  digit selects, active-low; slot n drives DIG[n].
REQ-011 SHALL have port HEX  output  4  hex code of the current slot's digit, for the 7-segment decoder.
REQ-012 SHALL have port DP  output  1  decimal point of the current slot.
REQ-013 SHALL have port FRAME  output  1  high for exactly cycle 0 of slot 0.
REQ-014 SHALL have port PEND  output  1  high while a loaded update awaits commit.

Function
REQ-015 SHALL drive all outputs from registers.
REQ-016 SHALL count a cycle counter c = 0..CLK_DIV-1 per slot and a 2-bit slot index 0,1,2,3, wrapping 3 -> 0.
REQ-017 SHALL run a per-slot state machine BLANK (c < BLANK_CYCLES) -> ON (c >= BLANK_CYCLES) -> BLANK at the next slot start.
REQ-018 SHALL hold DIG = 4'b1111 throughout BLANK.
REQ-019 SHALL update HEX and DP at c = 0 of every slot from the active buffer, so both are stable before any DIG assertion.
REQ-020 SHALL, in ON, drive DIG[n] low only when DIG_EN[n] of the active buffer is 1; all other DIG bits SHALL stay high.
REQ-021 SHALL never drive more than one DIG bit low in any cycle.
REQ-022 SHALL, on LOAD, copy DATA, DP_IN and DIG_EN into the pending buffer and set PEND on the next cycle.
REQ-023 SHALL overwrite the pending buffer when a second LOAD arrives before commit; the last LOAD wins.
REQ-024 SHALL commit pending to active only at c = 0 of slot 0, and SHALL clear PEND in that same cycle.
REQ-025 SHALL, when LOAD coincides with the commit cycle, commit that LOAD's data directly and leave PEND low.
REQ-026 SHALL keep frame timing independent of LOAD activity; a disabled digit keeps its full slot time.

Reset
REQ-027 SHALL, while RST_N = 0, asynchronously force DIG = 4'b1111, HEX = 0, DP = 0, FRAME = 0 and PEND = 0.
REQ-028 SHALL also force c = 0, slot = 0, state BLANK, active and pending buffers to 0, so all digits are dark after reset.
REQ-029 SHALL, after RST_N deasserts, assert FRAME on the first rising CLK edge, then resume normal scanning.
REQ-030 SHALL, on reset mid-slot or mid-frame, discard any pending update.

Configuration
REQ-031 SHALL support macro DISP_DIMMING_EN.
REQ-032 With DISP_DIMMING_EN defined: the ON phase SHALL be split into 16 equal slices of (CLK_DIV-BLANK_CYCLES)/16 cycles; the enabled DIG bit SHALL be low only in slices with index < BRIGHT.
REQ-033 With DISP_DIMMING_EN defined: BRIGHT = 0 gives a dark display, and BRIGHT = 15 gives 15/16 of ON.
REQ-034 Without DISP_DIMMING_EN: BRIGHT SHALL be ignored and the enabled DIG bit SHALL be low for the whole ON phase.
REQ-035 Parameter constraints: BLANK_CYCLES >= 1; CLK_DIV > BLANK_CYCLES; (CLK_DIV-BLANK_CYCLES) divisible by 16.

Verification
All scenarios use CLK_DIV = 64 and BLANK_CYCLES = 16 (ON = 48 cycles, slice = 3 cycles).
REQ-036 Reset release -> FRAME at cycle 0; DIG = 1111 for 256 cycles (all enables 0); FRAME repeats every 256 cycles.
REQ-037 LOAD DATA=16'h4321, DIG_EN=4'hF mid-frame -> PEND=1 until next FRAME; then slot n shows HEX = n+1 and DIG = 1110, 1101, 1011, 0111 during c = 16..63 only.
REQ-038 Two LOADs (16'h1111 then 16'h2222) in one frame -> only 2222 is ever displayed; LOAD on the FRAME cycle -> PEND stays 0 and the data shows in that frame.
REQ-039 DIG_EN = 4'b0101 -> DIG[1] and DIG[3] never go low, and slot timing is unchanged.
REQ-040 DISP_DIMMING_EN defined with BRIGHT = 4 -> DIG low for 12 of 64 cycles per slot (c = 16..27); BRIGHT = 0 -> never low. Undefined -> 48 cycles low regardless of BRIGHT.
REQ-041 RST_N low at slot 2, c = 30, with PEND = 1 -> outputs reset immediately without a clock; the pending data is never displayed.
